// File: rtl/pipe_mult_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_mult_sched_if
// Description : Bundle of request, multiplier and result signals between the
//               pipe_mult_sched scheduler and its clients / multiplier chain.
//               Optional grant counters appear when PIPE_SCHED_PERF_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_mult_sched_if #(
    parameter int CNT_W = 3
);
    logic             en;
    logic             req0_valid;
    logic             req0_ready;
    logic [0:31]      req0_x;
    logic [0:31]      req0_y;
    logic             req1_valid;
    logic             req1_ready;
    logic [0:31]      req1_x;
    logic [0:31]      req1_y;
    logic [0:31]      mul_x;
    logic [0:31]      mul_y;
    logic [0:31]      mul_out;
    logic [0:31]      res_data;
    logic             res0_valid;
    logic             res1_valid;
    logic [CNT_W-1:0] inflight;
    logic             idle;
`ifdef PIPE_SCHED_PERF_EN
    logic [15:0]      grant0_cnt;
    logic [15:0]      grant1_cnt;

    // Scheduler side
    modport slave (
        input  en, req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y, mul_out,
        output req0_ready, req1_ready, mul_x, mul_y, res_data, res0_valid, res1_valid,
               inflight, idle, grant0_cnt, grant1_cnt
    );

    // Client / environment side
    modport master (
        output en, req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y, mul_out,
        input  req0_ready, req1_ready, mul_x, mul_y, res_data, res0_valid, res1_valid,
               inflight, idle, grant0_cnt, grant1_cnt
    );
`else
    // Scheduler side
    modport slave (
        input  en, req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y, mul_out,
        output req0_ready, req1_ready, mul_x, mul_y, res_data, res0_valid, res1_valid,
               inflight, idle
    );

    // Client / environment side
    modport master (
        output en, req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y, mul_out,
        input  req0_ready, req1_ready, mul_x, mul_y, res_data, res0_valid, res1_valid,
               inflight, idle
    );
`endif
endinterface
`default_nettype wire

// File: rtl/pipe_mult_sched.sv
`default_nettype none
// ============================================================================
// Module      : pipe_mult_sched
// Description : Round-robin scheduler sharing one pipelined FP32 multiplier
//               between two requesters. Issues at most one operand pair per
//               cycle from registers, tracks each op with a tag shift register
//               and steers the result back to its issuer.
//               Optional macro PIPE_SCHED_PERF_EN adds per-requester grant
//               counters (grant0_cnt / grant1_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_mult_sched #(
    parameter int PIPE_LAT = 3,
    parameter int CNT_W    = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pipe_mult_sched_if.slave   bus
);

    localparam int TAG_N = PIPE_LAT + 1;

    // Grant logic signals
    logic w_req0;
    logic w_req1;
    logic w_xfer;
    logic w_gnt_id;

    // Registered state
    logic             rr_ptr_q,   rr_ptr_d;
    logic [0:31]      mul_x_q,    mul_x_d;
    logic [0:31]      mul_y_q,    mul_y_d;
    logic [TAG_N-1:0] tag_v_q,    tag_v_d;
    logic [TAG_N-1:0] tag_id_q,   tag_id_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;

    logic w_last_v;
    logic w_last_id;

    // Grant arbitration: requests are masked while disabled or held in reset
    always_comb begin
        w_req0   = bus.en & bus.req0_valid & ~rst;
        w_req1   = bus.en & bus.req1_valid & ~rst;
        w_xfer   = w_req0 | w_req1;
        w_gnt_id = (w_req0 & w_req1) ? rr_ptr_q : w_req1;
    end

    assign bus.req0_ready = w_xfer & ~w_gnt_id;
    assign bus.req1_ready = w_xfer &  w_gnt_id;

    assign w_last_v  = tag_v_q[TAG_N-1];
    assign w_last_id = tag_id_q[TAG_N-1];

    // Next-state for pointer, issue registers, tag pipe and in-flight counter
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        mul_x_d    = mul_x_q;
        mul_y_d    = mul_y_q;
        inflight_d = inflight_q;

        if (w_xfer) begin
            rr_ptr_d = ~w_gnt_id;
            mul_x_d  = w_gnt_id ? bus.req1_x : bus.req0_x;
            mul_y_d  = w_gnt_id ? bus.req1_y : bus.req0_y;
        end

        // Tags advance every cycle; stage 0 is loaded alongside mul_x/mul_y
        if (TAG_N > 1) begin
            tag_v_d  = {tag_v_q[TAG_N-2:0],  w_xfer};
            tag_id_d = {tag_id_q[TAG_N-2:0], w_gnt_id};
        end else begin
            tag_v_d  = TAG_N'(w_xfer);
            tag_id_d = TAG_N'(w_gnt_id);
        end

        // Issue and retire in the same cycle cancel out
        case ({w_xfer, w_last_v})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // State registers; reset discards every in-flight tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= 1'b0;
            mul_x_q    <= 32'h0;
            mul_y_q    <= 32'h0;
            tag_v_q    <= '0;
            tag_id_q   <= '0;
            inflight_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            mul_x_q    <= mul_x_d;
            mul_y_q    <= mul_y_d;
            tag_v_q    <= tag_v_d;
            tag_id_q   <= tag_id_d;
            inflight_q <= inflight_d;
        end
    end

    assign bus.mul_x      = mul_x_q;
    assign bus.mul_y      = mul_y_q;
    assign bus.res_data   = bus.mul_out;
    assign bus.res0_valid = w_last_v & ~w_last_id;
    assign bus.res1_valid = w_last_v &  w_last_id;
    assign bus.inflight   = inflight_q;
    assign bus.idle       = (inflight_q == '0) & ~w_xfer;

`ifdef PIPE_SCHED_PERF_EN
    logic [15:0] grant0_cnt_q, grant0_cnt_d;
    logic [15:0] grant1_cnt_q, grant1_cnt_d;

    // Grant counters wrap naturally at 16 bits
    always_comb begin
        grant0_cnt_d = grant0_cnt_q + 16'(bus.req0_ready);
        grant1_cnt_d = grant1_cnt_q + 16'(bus.req1_ready);
    end

    // Grant counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant0_cnt_q <= 16'h0;
            grant1_cnt_q <= 16'h0;
        end else begin
            grant0_cnt_q <= grant0_cnt_d;
            grant1_cnt_q <= grant1_cnt_d;
        end
    end

    assign bus.grant0_cnt = grant0_cnt_q;
    assign bus.grant1_cnt = grant1_cnt_q;
`endif

endmodule
`default_nettype wire
